// File: rtl/cpu_output_gen.sv
// Formats one CPU trace record ("^TIME@PC: $GRF <= DATA#" or "^TIME@PC: *ADDR <= DATA#") as a stream of ASCII characters.
// Define CPU_OUTPUT_GEN_UPPER_HEX_EN to emit hex digits as 'A'..'F' instead of 'a'..'f'.
module cpu_output_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        fmt,
  input  logic [13:0] time_val,
  input  logic [31:0] pc,
  input  logic [4:0]  grf,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic        ready,
  output logic [7:0]  char,
  output logic        char_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CONV, EMIT, DONE} state_t;
  typedef enum logic [3:0] {
    S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP0, S_TAG,
    S_OPND, S_SP1, S_LT, S_EQ, S_SP2, S_DATA, S_HASH
  } seq_t;

  state_t      state, state_n;
  seq_t        seq, seq_n, seq_nx;
  logic [2:0]  dcnt, dcnt_n;
  logic [3:0]  conv_cnt;
  logic        accept, reject;

  logic        fmt_q;
  logic [31:0] pc_q, addr_q, data_q;
  logic [13:0] bin_t, bin_g;
  logic [15:0] bcd_t, t_adj;
  logic [7:0]  bcd_g, g_adj;
  logic [2:0]  t_last;
  logic        g_last;
  logic [3:0]  t_dig, g_dig, pc_nib, addr_nib, data_nib;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) r = 8'h30 + {4'h0, n};
`ifdef CPU_OUTPUT_GEN_UPPER_HEX_EN
    else r = 8'h37 + {4'h0, n};
`else
    else r = 8'h57 + {4'h0, n};
`endif
    return r;
  endfunction

  function automatic logic [15:0] dd_adj16(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int unsigned i = 0; i < 4; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] dd_adj8(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    for (int unsigned i = 0; i < 2; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  // Both conversions run 14 steps; grf is zero-extended so the leading
  // zero shifts leave its BCD untouched until its own bits arrive.
  assign t_adj = dd_adj16(bcd_t);
  assign g_adj = dd_adj8(bcd_g);

  assign t_last = (bcd_t[15:12] != 4'd0) ? 3'd3 :
                  (bcd_t[11:8]  != 4'd0) ? 3'd2 :
                  (bcd_t[7:4]   != 4'd0) ? 3'd1 : 3'd0;
  assign g_last = (bcd_g[7:4] != 4'd0);

  assign t_dig    = bcd_t[{dcnt[1:0], 2'b00} +: 4];
  assign g_dig    = bcd_g[{dcnt[0], 2'b00} +: 4];
  assign pc_nib   = pc_q[{dcnt, 2'b00} +: 4];
  assign addr_nib = addr_q[{dcnt, 2'b00} +: 4];
  assign data_nib = data_q[{dcnt, 2'b00} +: 4];
  assign seq_nx   = seq_t'(seq + 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      seq   <= S_CARET;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      seq   <= seq_n;
      dcnt  <= dcnt_n;
    end
  end

  // dcnt counts down the digits of the current field; 0 means last char of it.
  always_comb begin
    state_n = state;
    seq_n   = seq;
    dcnt_n  = dcnt;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (time_val <= 14'd9999) begin
            accept  = 1'b1;
            state_n = CONV;
          end else begin
            reject = 1'b1;
          end
        end
      end
      CONV: begin
        if (conv_cnt == 4'd13) begin
          state_n = EMIT;
          seq_n   = S_CARET;
          dcnt_n  = '0;
        end
      end
      EMIT: begin
        if (ready) begin
          if (dcnt != 3'd0) begin
            dcnt_n = dcnt - 3'd1;
          end else if (seq == S_HASH) begin
            state_n = DONE;
          end else begin
            seq_n = seq_nx;
            case (seq_nx)
              S_TIME:        dcnt_n = t_last;
              S_PC, S_DATA:  dcnt_n = 3'd7;
              S_OPND:        dcnt_n = fmt_q ? 3'd7 : {2'b00, g_last};
              default:       dcnt_n = '0;
            endcase
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err      <= 1'b0;
      fmt_q    <= 1'b0;
      pc_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      bin_t    <= '0;
      bin_g    <= '0;
      bcd_t    <= '0;
      bcd_g    <= '0;
      conv_cnt <= '0;
    end else begin
      err <= reject;
      if (accept) begin
        fmt_q    <= fmt;
        pc_q     <= pc;
        addr_q   <= addr;
        data_q   <= data;
        bin_t    <= time_val;
        bin_g    <= {9'd0, grf};
        bcd_t    <= '0;
        bcd_g    <= '0;
        conv_cnt <= '0;
      end else if (state == CONV) begin
        bcd_t    <= {t_adj[14:0], bin_t[13]};
        bcd_g    <= {g_adj[6:0], bin_g[13]};
        bin_t    <= {bin_t[12:0], 1'b0};
        bin_g    <= {bin_g[12:0], 1'b0};
        conv_cnt <= conv_cnt + 4'd1;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign char_valid = (state == EMIT);

  always_comb begin
    char = 8'h00;
    if (state == EMIT) begin
      case (seq)
        S_CARET: char = 8'h5E;
        S_TIME:  char = {4'h3, t_dig};
        S_AT:    char = 8'h40;
        S_PC:    char = hex_char(pc_nib);
        S_COLON: char = 8'h3A;
        S_SP0,
        S_SP1,
        S_SP2:   char = 8'h20;
        S_TAG:   char = fmt_q ? 8'h2A : 8'h24;
        S_OPND:  char = fmt_q ? hex_char(addr_nib) : {4'h3, g_dig};
        S_LT:    char = 8'h3C;
        S_EQ:    char = 8'h3D;
        S_DATA:  char = hex_char(data_nib);
        S_HASH:  char = 8'h23;
        default: char = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_output_gen.sv
// Scoreboard bench for cpu_output_gen: expected record text is queued per start and
// popped on every char_valid && ready transfer.
module tb_cpu_output_gen;

  logic        clk = 1'b0;
  logic        reset, start, fmt, ready;
  logic [13:0] time_val;
  logic [31:0] pc, addr, data;
  logic [4:0]  grf;
  logic [7:0]  char;
  logic        char_valid, busy, done, err;

  int unsigned n_vec = 0, n_err = 0;
  logic [7:0]  exp_q[$];
  int          xfer_cnt, valid_cyc, done_cnt;
  bit          bp_mode = 1'b0;
  bit          stall_prev = 1'b0;
  logic [7:0]  char_prev;

  always #5 clk = ~clk;

  cpu_output_gen dut (
    .clk(clk), .reset(reset), .start(start), .fmt(fmt), .time_val(time_val),
    .pc(pc), .grf(grf), .addr(addr), .data(data), .ready(ready),
    .char(char), .char_valid(char_valid), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #2 ready = bp_mode ? ~ready : 1'b1;
    end
  end

  // Monitor: scoreboard pops, hold-under-backpressure, per-record counters.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (char_valid) valid_cyc++;
        if (stall_prev)
          check("hold", {23'd0, char_valid, char}, {23'd0, 1'b1, char_prev});
        if (char_valid && ready) begin
          if (exp_q.size() == 0) check("extra_char", {24'd0, char}, 32'd0);
          else check("char", {24'd0, char}, {24'd0, exp_q.pop_front()});
          xfer_cnt++;
        end
        if (done) done_cnt++;
        stall_prev = char_valid && !ready;
        char_prev  = char;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic push_rec(input bit f, input logic [13:0] t, input logic [31:0] p,
                          input logic [4:0] g, input logic [31:0] a, input logic [31:0] d,
                          output int len);
    string s;
    if (f) s = $sformatf("^%0d@%08h: *%08h <= %08h#", t, p, a, d);
    else   s = $sformatf("^%0d@%08h: $%0d <= %08h#", t, p, g, d);
`ifdef CPU_OUTPUT_GEN_UPPER_HEX_EN
    s = s.toupper();
`endif
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    len = s.len();
    xfer_cnt = 0; valid_cyc = 0; done_cnt = 0;
    fmt = f; time_val = t; pc = p; grf = g; addr = a; data = d; start = 1'b1;
  endtask

  // Caller aligns to posedge+2 before calling; start is raised immediately.
  task automatic run_rec(input bit f, input logic [13:0] t, input logic [31:0] p,
                         input logic [4:0] g, input logic [31:0] a, input logic [31:0] d,
                         input bit bp);
    int len;
    bit seen;
    bp_mode = bp;
    push_rec(f, t, p, g, a, d, len);
    @(posedge clk); #2;
    start = 1'b0;
    check("busy_on", busy, 1);
    fmt = ~f; time_val = 14'($urandom); pc = $urandom; grf = 5'($urandom);
    addr = $urandom; data = $urandom;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    check("err_busy", err, 0);
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("busy_in_done", busy, 1);
    check("cv_in_done", char_valid, 0);
    @(posedge clk); #1;
    check("busy_off", busy, 0);
    check("done_once", done_cnt, 1);
    check("rec_len", xfer_cnt, len);
    check("q_left", exp_q.size(), 0);
    if (bp) check("emit_cyc_bp", (valid_cyc == 2*len-1 || valid_cyc == 2*len), 1);
    else    check("emit_cyc", valid_cyc, len);
    bp_mode = 1'b0;
  endtask

  task automatic align;
    @(posedge clk); #2;
  endtask

  initial begin
    int  len;
    bit  seen;
    reset = 1'b0; start = 1'b0; fmt = 1'b0; time_val = '0; pc = '0; grf = '0;
    addr = '0; data = '0;
    #1;
    check("rst_char", char, 0);
    check("rst_cv", char_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // Release and start together: the first edge with reset high must take it.
    align; reset = 1'b1;
    run_rec(1'b0, 14'd1024, 32'h00003000, 5'd2, 32'h0, 32'h89abcdef, 1'b0);
    align; run_rec(1'b1, 14'd0, 32'h00003004, 5'd7, 32'h0000001c, 32'h00000000, 1'b0);
    align; run_rec(1'b0, 14'd1024, 32'h00003000, 5'd2, 32'h0, 32'h89abcdef, 1'b1);
    align; run_rec(1'b0, 14'd9999, 32'hffffffff, 5'd31, 32'h0, 32'hdeadbeef, 1'b0);
    align; run_rec(1'b0, 14'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
    align; run_rec(1'b0, 14'd9, 32'h12345678, 5'd9, 32'h0, 32'habcdef01, 1'b1);
    align; run_rec(1'b0, 14'd10, 32'h0, 5'd10, 32'h0, 32'h1, 1'b0);
    align; run_rec(1'b1, 14'd99, 32'ha0b0c0d0, 5'd0, 32'hfedcba98, 32'h7, 1'b0);
    align; run_rec(1'b1, 14'd100, 32'h1, 5'd0, 32'h10, 32'h100, 1'b1);

    // Rejections: over-range time, err one cycle, nothing emitted.
    for (int k = 0; k < 2; k++) begin
      align; time_val = (k == 0) ? 14'd10000 : 14'd16383; start = 1'b1;
      align; start = 1'b0;
      check("rej_err", err, 1);
      check("rej_busy", busy, 0);
      check("rej_cv", char_valid, 0);
      @(posedge clk); #1;
      check("rej_err_clr", err, 0);
      check("rej_busy2", busy, 0);
    end

    // Reset mid-record after the 10th transferred char.
    align; bp_mode = 1'b0;
    push_rec(1'b0, 14'd1024, 32'h00003000, 5'd2, 32'h0, 32'h89abcdef, len);
    align; start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (xfer_cnt >= 10) seen = 1'b1;
    end
    check("reach_10", seen, 1);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check("mid_rst_char", char, 0);
    check("mid_rst_cv", char_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (20) @(posedge clk);
    align; run_rec(1'b0, 14'd1024, 32'h00003000, 5'd2, 32'h0, 32'h89abcdef, 1'b0);

    for (int n = 0; n < 6; n++) begin
      align;
      run_rec(1'($urandom), 14'($urandom_range(9999)), $urandom, 5'($urandom),
              $urandom, $urandom, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=0", $time);
    $fatal(1);
  end

endmodule
